line_buffer_row_scheduler: RTL and testbench

Sequencer for `input_line_buffer`: it generates the row-stream commands (`Stream_first_row`, `Stream_mid_row`, `Stream_last_row`) and the `last_channel` flag for one conv layer. It walks every channel of an `IMAGE_SIZE` x `IMAGE_SIZE` input and advances only when the buffer reports `Done_1row`. It sits between the layer-level control FSM (`start`/`done`) and the line buffer's control inputs.

---
 rtl/line_buffer_row_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_line_buffer_row_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_row_scheduler.sv
// line_buffer_row_scheduler
//
// Generates the row-stream commands and the last_channel flag for an input
// line buffer over one conv layer. The walk is channel outer, row inner. It
// advances only when the buffer reports Done_1row.
//
// Ports:
//   clk, Reset        - rising-edge clock, asynchronous active-low reset
//   start, abort      - begin a layer (sampled in IDLE only) / return to IDLE
//   IMAGE_SIZE        - rows per channel, latched on an accepted start
//   CHANNEL_SIZE      - channel count, latched on an accepted start
//   Done_1row         - buffer finished the current row pass (used in WAIT only)
//   Stream_*_row      - one-cycle command pulses (first / mid / last row)
//   last_channel      - high for the whole final channel
//   row_idx, ch_idx   - current row pass / channel
//   busy, done        - not-IDLE level / one-cycle layer-complete pulse
//   cfg_err           - one-cycle pulse when start is rejected for bad sizes
module line_buffer_row_scheduler #(
    parameter int unsigned IMG_W = 9,
    parameter int unsigned CH_W  = 10
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IMG_W-1:0] IMAGE_SIZE,
    input  logic [CH_W-1:0]  CHANNEL_SIZE,
    input  logic             Done_1row,
    output logic             Stream_first_row,
    output logic             Stream_mid_row,
    output logic             Stream_last_row,
    output logic             last_channel,
    output logic [IMG_W-1:0] row_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StNext,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [IMG_W-1:0] img_q, img_d;
    logic [CH_W-1:0]  chs_q, chs_d;
    logic [IMG_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             first_q, first_d;
    logic             mid_q, mid_d;
    logic             last_q, last_d;
    logic             lc_q, lc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    // Commands are decoded from the next-state row so they are registered on
    // the same edge that enters ISSUE; the pulse therefore covers exactly the
    // ISSUE cycle.
    always_comb begin
        state_d   = state_q;
        img_d     = img_q;
        chs_d     = chs_q;
        row_d     = row_q;
        ch_d      = ch_q;
        lc_d      = lc_q;
        first_d   = 1'b0;
        mid_d     = 1'b0;
        last_d    = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (IMAGE_SIZE >= IMG_W'(2) && CHANNEL_SIZE != '0) begin
                        img_d   = IMAGE_SIZE;
                        chs_d   = CHANNEL_SIZE;
                        row_d   = '0;
                        ch_d    = '0;
                        lc_d    = (CHANNEL_SIZE == CH_W'(1));
                        first_d = 1'b1;
                        state_d = StIssue;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (Done_1row) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (row_q < img_q - IMG_W'(1)) begin
                    row_d   = row_q + IMG_W'(1);
                    state_d = StIssue;
                    // Row 0 never reaches here, so first-row priority is implicit.
                    if (row_d == img_q - IMG_W'(1)) begin
                        last_d = 1'b1;
                    end else begin
                        mid_d = 1'b1;
                    end
                end else if (ch_q < chs_q - CH_W'(1)) begin
                    row_d   = '0;
                    ch_d    = ch_q + CH_W'(1);
                    lc_d    = (ch_d == chs_q - CH_W'(1));
                    first_d = 1'b1;
                    state_d = StIssue;
                end else begin
                    lc_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything; counters and latched sizes hold.
        if (abort) begin
            state_d   = StIdle;
            img_d     = img_q;
            chs_d     = chs_q;
            row_d     = row_q;
            ch_d      = ch_q;
            lc_d      = 1'b0;
            first_d   = 1'b0;
            mid_d     = 1'b0;
            last_d    = 1'b0;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            img_q     <= '0;
            chs_q     <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            lc_q      <= 1'b0;
            first_q   <= 1'b0;
            mid_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            img_q     <= img_d;
            chs_q     <= chs_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            lc_q      <= lc_d;
            first_q   <= first_d;
            mid_q     <= mid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign Stream_first_row = first_q;
    assign Stream_mid_row   = mid_q;
    assign Stream_last_row  = last_q;
    assign last_channel     = lc_q;
    assign row_idx          = row_q;
    assign ch_idx           = ch_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_line_buffer_row_scheduler.sv
// Testbench for line_buffer_row_scheduler: directed stimulus pushes expected
// events into a queue, and a negedge monitor pops and compares them whenever
// the DUT emits a command, done or cfg_err pulse.
module tb_line_buffer_row_scheduler;

    localparam int IMG_W = 9;
    localparam int CH_W  = 10;

    localparam logic [2:0] KF   = 3'd0;
    localparam logic [2:0] KM   = 3'd1;
    localparam logic [2:0] KL   = 3'd2;
    localparam logic [2:0] KDN  = 3'd3;
    localparam logic [2:0] KERR = 3'd4;

    logic             clk = 1'b0;
    logic             Reset;
    logic             start;
    logic             abort;
    logic [IMG_W-1:0] IMAGE_SIZE;
    logic [CH_W-1:0]  CHANNEL_SIZE;
    logic             Done_1row;
    logic             Stream_first_row;
    logic             Stream_mid_row;
    logic             Stream_last_row;
    logic             last_channel;
    logic [IMG_W-1:0] row_idx;
    logic [CH_W-1:0]  ch_idx;
    logic             busy;
    logic             done;
    logic             cfg_err;

    line_buffer_row_scheduler #(
        .IMG_W(IMG_W),
        .CH_W (CH_W)
    ) dut (
        .clk             (clk),
        .Reset           (Reset),
        .start           (start),
        .abort           (abort),
        .IMAGE_SIZE      (IMAGE_SIZE),
        .CHANNEL_SIZE    (CHANNEL_SIZE),
        .Done_1row       (Done_1row),
        .Stream_first_row(Stream_first_row),
        .Stream_mid_row  (Stream_mid_row),
        .Stream_last_row (Stream_last_row),
        .last_channel    (last_channel),
        .row_idx         (row_idx),
        .ch_idx          (ch_idx),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       kind;
        logic             lc;
        logic [IMG_W-1:0] row;
        logic [CH_W-1:0]  ch;
        logic             chk_idx;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  n_cmds    = 0;
    int  exp_cmds  = 0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int cmd_any();
        return int'(Stream_first_row | Stream_mid_row | Stream_last_row);
    endfunction

    function automatic void push_ev(logic [2:0] k, logic lc, int r, int c, logic ci);
        ev_t e;
        e.kind    = k;
        e.lc      = lc;
        e.row     = IMG_W'(r);
        e.ch      = CH_W'(c);
        e.chk_idx = ci;
        exp_q.push_back(e);
    endfunction

    // Expected command stream for a whole layer followed by its done pulse.
    function automatic void push_layer(int img, int chs);
        for (int c = 0; c < chs; c++) begin
            for (int r = 0; r < img; r++) begin
                push_ev((r == 0) ? KF : ((r == img - 1) ? KL : KM), (c == chs - 1), r, c,
                        1'b1);
            end
        end
        push_ev(KDN, 1'b0, img - 1, chs - 1, 1'b1);
    endfunction

    // Monitor
    ev_t mon_got;
    ev_t mon_want;
    int  mon_hits;

    always @(negedge clk) begin : monitor
        mon_hits = int'(Stream_first_row) + int'(Stream_mid_row) + int'(Stream_last_row)
                 + int'(done) + int'(cfg_err);
        if (mon_hits != 0) begin
            if (mon_hits > 1)          mon_got.kind = 3'd7;
            else if (Stream_first_row) mon_got.kind = KF;
            else if (Stream_mid_row)   mon_got.kind = KM;
            else if (Stream_last_row)  mon_got.kind = KL;
            else if (done)             mon_got.kind = KDN;
            else                       mon_got.kind = KERR;
            mon_got.lc      = last_channel;
            mon_got.row     = row_idx;
            mon_got.ch      = ch_idx;
            mon_got.chk_idx = 1'b1;
            if (cmd_any() != 0) n_cmds++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got kind=%0d lc=%0d row=%0d ch=%0d, expected none (t=%0t)",
                         mon_got.kind, mon_got.lc, mon_got.row, mon_got.ch, $time);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got.kind != mon_want.kind ||
                    (mon_want.chk_idx && (mon_got.lc != mon_want.lc ||
                     mon_got.row != mon_want.row || mon_got.ch != mon_want.ch))) begin
                    n_fail++;
                    $display("FAIL event: got kind=%0d lc=%0d row=%0d ch=%0d, expected kind=%0d lc=%0d row=%0d ch=%0d (t=%0t)",
                             mon_got.kind, mon_got.lc, mon_got.row, mon_got.ch,
                             mon_want.kind, mon_want.lc, mon_want.row, mon_want.ch, $time);
                end
            end
        end
    end

    task automatic do_start(int img, int chs);
        IMAGE_SIZE   = IMG_W'(img);
        CHANNEL_SIZE = CH_W'(chs);
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cmd_any() != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("cmd_timeout", 0, 1);
    endtask

    // Answers n commands with Done_1row 5 cycles later and checks latencies.
    task automatic serve(int n, bit stray, bit fin);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_cmd(ok);
            if (!ok) return;
            if (stray && i == 1) begin
                Done_1row = 1'b1;          // during the ISSUE cycle: ignored
                @(negedge clk);
                Done_1row  = 1'b0;
                start      = 1'b1;         // during WAIT: ignored
                IMAGE_SIZE = IMG_W'(7);    // mid-layer size change: ignored
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
                check("stray_no_advance", cmd_any(), 0);
            end
            repeat (4) @(negedge clk);
            Done_1row = 1'b1;
            @(negedge clk);
            Done_1row = 1'b0;
            check("gap_after_done_1row", cmd_any(), 0);
            @(negedge clk);
            if (i < n - 1 || !fin) begin
                check("row_latency", cmd_any(), 1);
            end else begin
                check("done_latency", int'(done), 1);
                check("busy_at_done", int'(busy), 1);
                @(negedge clk);
                check("busy_after_done", int'(busy), 0);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit ok;
        Reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        Done_1row    = 1'b0;
        IMAGE_SIZE   = '0;
        CHANNEL_SIZE = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_cmds", cmd_any(), 0);
        check("rst_lc", int'(last_channel), 0);
        check("rst_done_err", int'(done | cfg_err), 0);
        check("rst_row", int'(row_idx), 0);
        check("rst_ch", int'(ch_idx), 0);
        Reset = 1'b1;
        @(negedge clk);
        check("release_no_pulse", cmd_any() + int'(done) + int'(cfg_err), 0);

        // Nominal 4 x 2
        push_layer(4, 2);
        do_start(4, 2);
        check("start_latency", int'(Stream_first_row), 1);
        serve(8, 1'b0, 1'b1);
        exp_cmds += 8;

        // 2 x 1: first then last, last_channel from the first command
        push_layer(2, 1);
        do_start(2, 1);
        check("start_latency_2x1", int'(Stream_first_row), 1);
        check("lc_2x1", int'(last_channel), 1);
        serve(2, 1'b0, 1'b1);
        exp_cmds += 2;

        // Illegal sizes
        push_ev(KERR, 1'b0, 0, 0, 1'b0);
        do_start(1, 2);
        check("busy_img1", int'(busy), 0);
        @(negedge clk);
        check("busy_img1_later", int'(busy), 0);
        push_ev(KERR, 1'b0, 0, 0, 1'b0);
        do_start(4, 0);
        check("busy_ch0", int'(busy), 0);
        @(negedge clk);
        check("busy_ch0_later", int'(busy), 0);

        // start and abort together in IDLE
        abort = 1'b1;
        do_start(4, 2);
        abort = 1'b0;
        check("busy_start_abort", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Abort during WAIT of row 2, channel 0 (the only, hence last, channel)
        push_ev(KF, 1'b1, 0, 0, 1'b1);
        push_ev(KM, 1'b1, 1, 0, 1'b1);
        push_ev(KM, 1'b1, 2, 0, 1'b1);
        do_start(4, 1);
        serve(2, 1'b0, 1'b0);
        wait_cmd(ok);
        @(negedge clk);
        check("lc_before_abort", int'(last_channel), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_lc", int'(last_channel), 0);
        check("abort_row_held", int'(row_idx), 2);
        repeat (8) @(negedge clk);
        check("abort_stays_idle", int'(busy), 0);
        exp_cmds += 3;

        // Restart after abort
        push_layer(3, 2);
        do_start(3, 2);
        check("restart_row", int'(row_idx), 0);
        check("restart_ch", int'(ch_idx), 0);
        serve(6, 1'b0, 1'b1);
        exp_cmds += 6;

        // Asynchronous reset during ISSUE
        push_ev(KF, 1'b0, 0, 0, 1'b1);
        do_start(3, 2);
        #2 Reset = 1'b0;
        #1;
        check("async_rst_cmd", cmd_any(), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);
        exp_cmds += 1;

        // Stray handshakes
        Done_1row = 1'b1;
        repeat (4) @(negedge clk);
        check("done_1row_in_idle", int'(busy), 0);
        Done_1row = 1'b0;
        push_layer(3, 2);
        do_start(3, 2);
        serve(6, 1'b1, 1'b1);
        exp_cmds += 6;

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("cmd_count", n_cmds, exp_cmds);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
